// File: rtl/ram_arbiter.sv
// Two-port round-robin arbiter for a single-port RAM with bounded locked bursts.
// Optional statistics counters are enabled by defining ARB_STATS_EN.
module ram_arbiter #(
  parameter int WIDTH    = 32,
  parameter int MAX_LOCK = 16,
  parameter int RD_LAT   = 1
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             req0,
  input  logic             req1,
  input  logic             lock0,
  input  logic             lock1,
  input  logic             we0,
  input  logic             we1,
  input  logic [WIDTH-1:0] addr0,
  input  logic [WIDTH-1:0] addr1,
  input  logic [WIDTH-1:0] wdata0,
  input  logic [WIDTH-1:0] wdata1,
  output logic             gnt0,
  output logic             gnt1,
  output logic             rvalid0,
  output logic             rvalid1,
  output logic [WIDTH-1:0] rdata0,
  output logic [WIDTH-1:0] rdata1,
  output logic [WIDTH-1:0] mem_addr,
  output logic [WIDTH-1:0] mem_wdata,
  output logic             mem_we,
  input  logic [WIDTH-1:0] mem_rdata
`ifdef ARB_STATS_EN
  ,
  output logic [31:0]      conflicts,
  output logic [31:0]      stall0,
  output logic [31:0]      stall1
`endif
);

  localparam int LCW = $clog2(MAX_LOCK) + 1;
  localparam logic [LCW-1:0] MAX_CNT = LCW'(MAX_LOCK);

  typedef enum logic [1:0] {IDLE = 2'd0, OWN0 = 2'd1, OWN1 = 2'd2} owner_t;

  owner_t           state_r;
  logic             last_r;
  logic [LCW-1:0]   lock_cnt_r;
  logic             gnt0_s;
  logic             gnt1_s;
  logic [RD_LAT-1:0] rd0_pipe_r;
  logic [RD_LAT-1:0] rd1_pipe_r;
  logic [WIDTH-1:0] rdata0_hold_r;
  logic [WIDTH-1:0] rdata1_hold_r;

  // Saturating lock-length update for the port being granted.
  function automatic logic [LCW-1:0] next_cnt(input logic lk, input logic same_owner,
                                               input logic [LCW-1:0] cnt);
    if (!lk) begin
      next_cnt = {LCW{1'b0}};
    end else if (!same_owner) begin
      next_cnt = LCW'(1);
    end else if (cnt == MAX_CNT) begin
      next_cnt = cnt;
    end else begin
      next_cnt = cnt + LCW'(1);
    end
  endfunction

  // Grant decision: locked owner, forced release at MAX_LOCK, else round robin.
  always_comb begin
    gnt0_s = 1'b0;
    gnt1_s = 1'b0;
    if (reset) begin
      gnt0_s = 1'b0;
      gnt1_s = 1'b0;
    end else if (state_r == OWN0 && lock0 && lock_cnt_r < MAX_CNT) begin
      gnt0_s = req0;
    end else if (state_r == OWN1 && lock1 && lock_cnt_r < MAX_CNT) begin
      gnt1_s = req1;
    end else if (state_r == OWN0 && lock0) begin
      if (req1) begin
        gnt1_s = 1'b1;
      end else begin
        gnt0_s = req0;
      end
    end else if (state_r == OWN1 && lock1) begin
      if (req0) begin
        gnt0_s = 1'b1;
      end else begin
        gnt1_s = req1;
      end
    end else if (req0 && req1) begin
      gnt0_s = last_r;
      gnt1_s = ~last_r;
    end else begin
      gnt0_s = req0;
      gnt1_s = req1;
    end
  end

  assign gnt0 = gnt0_s;
  assign gnt1 = gnt1_s;

  // RAM-side mux from whichever port holds the grant.
  always_comb begin
    mem_addr  = {WIDTH{1'b0}};
    mem_wdata = {WIDTH{1'b0}};
    mem_we    = 1'b0;
    if (gnt0_s) begin
      mem_addr  = addr0;
      mem_wdata = wdata0;
      mem_we    = we0;
    end else if (gnt1_s) begin
      mem_addr  = addr1;
      mem_wdata = wdata1;
      mem_we    = we1;
    end else begin
      mem_we    = 1'b0;
    end
  end

  // Ownership state, last-served port and lock length.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_r    <= IDLE;
      last_r     <= 1'b1;
      lock_cnt_r <= {LCW{1'b0}};
    end else if (gnt0_s) begin
      state_r    <= OWN0;
      last_r     <= 1'b0;
      lock_cnt_r <= next_cnt(lock0, state_r == OWN0, lock_cnt_r);
    end else if (gnt1_s) begin
      state_r    <= OWN1;
      last_r     <= 1'b1;
      lock_cnt_r <= next_cnt(lock1, state_r == OWN1, lock_cnt_r);
    end else begin
      case (state_r)
        OWN0: begin
          if (!req0 && !lock0) state_r <= IDLE;
          if (!lock0) lock_cnt_r <= {LCW{1'b0}};
        end
        OWN1: begin
          if (!req1 && !lock1) state_r <= IDLE;
          if (!lock1) lock_cnt_r <= {LCW{1'b0}};
        end
        default: begin
          state_r    <= IDLE;
          lock_cnt_r <= {LCW{1'b0}};
        end
      endcase
    end
  end

  // Read-return tag pipeline and per-port data hold registers.
  always_ff @(posedge clock) begin
    if (reset) begin
      rd0_pipe_r    <= {RD_LAT{1'b0}};
      rd1_pipe_r    <= {RD_LAT{1'b0}};
      rdata0_hold_r <= {WIDTH{1'b0}};
      rdata1_hold_r <= {WIDTH{1'b0}};
    end else begin
      rd0_pipe_r[0] <= gnt0_s & ~we0;
      rd1_pipe_r[0] <= gnt1_s & ~we1;
      for (int i = 1; i < RD_LAT; i++) begin
        rd0_pipe_r[i] <= rd0_pipe_r[i-1];
        rd1_pipe_r[i] <= rd1_pipe_r[i-1];
      end
      if (rvalid0) rdata0_hold_r <= mem_rdata;
      if (rvalid1) rdata1_hold_r <= mem_rdata;
    end
  end

  // Returned data is only on mem_rdata during the valid cycle, so pass it through then.
  assign rvalid0 = rd0_pipe_r[RD_LAT-1] & ~reset;
  assign rvalid1 = rd1_pipe_r[RD_LAT-1] & ~reset;
  assign rdata0  = rvalid0 ? mem_rdata : rdata0_hold_r;
  assign rdata1  = rvalid1 ? mem_rdata : rdata1_hold_r;

`ifdef ARB_STATS_EN
  // Saturating contention and stall counters.
  always_ff @(posedge clock) begin
    if (reset) begin
      conflicts <= 32'd0;
      stall0    <= 32'd0;
      stall1    <= 32'd0;
    end else begin
      if (req0 && req1 && conflicts != 32'hFFFF_FFFF) conflicts <= conflicts + 32'd1;
      if (req0 && !gnt0_s && stall0 != 32'hFFFF_FFFF) stall0 <= stall0 + 32'd1;
      if (req1 && !gnt1_s && stall1 != 32'hFFFF_FFFF) stall1 <= stall1 + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_ram_arbiter.sv
// Directed self-checking bench for ram_arbiter with a synchronous RAM model (RD_LAT=1).
module tb_ram_arbiter;
  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        req0 = 1'b0, req1 = 1'b0, lock0 = 1'b0, lock1 = 1'b0;
  logic        we0 = 1'b0, we1 = 1'b0;
  logic [31:0] addr0 = 32'd0, addr1 = 32'd0, wdata0 = 32'd0, wdata1 = 32'd0;
  logic        gnt0, gnt1, rvalid0, rvalid1, mem_we;
  logic [31:0] rdata0, rdata1, mem_addr, mem_wdata;
  logic [31:0] mem_rdata = 32'd0;
`ifdef ARB_STATS_EN
  logic [31:0] conflicts, stall0, stall1;
`endif
  logic [31:0] ram [0:255];
  int errors = 0;
  int checks = 0;

  ram_arbiter #(.WIDTH(32), .MAX_LOCK(4), .RD_LAT(1)) dut (
    .clock(clock), .reset(reset),
    .req0(req0), .req1(req1), .lock0(lock0), .lock1(lock1),
    .we0(we0), .we1(we1), .addr0(addr0), .addr1(addr1),
    .wdata0(wdata0), .wdata1(wdata1),
    .gnt0(gnt0), .gnt1(gnt1), .rvalid0(rvalid0), .rvalid1(rvalid1),
    .rdata0(rdata0), .rdata1(rdata1),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we),
    .mem_rdata(mem_rdata)
`ifdef ARB_STATS_EN
    , .conflicts(conflicts), .stall0(stall0), .stall1(stall1)
`endif
  );

  always #5 clock = ~clock;

  always @(posedge clock) begin
    if (mem_we) ram[mem_addr[7:0]] <= mem_wdata;
    mem_rdata <= ram[mem_addr[7:0]];
  end

  task automatic idle_inputs();
    req0 = 1'b0; req1 = 1'b0; lock0 = 1'b0; lock1 = 1'b0; we0 = 1'b0; we1 = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clock);
    idle_inputs();
    reset = 1'b1;
    repeat (2) @(posedge clock);
    @(negedge clock);
    reset = 1'b0;
  endtask

  task automatic test_reset();
    @(negedge clock);
    reset = 1'b1; req0 = 1'b1; req1 = 1'b1; we0 = 1'b1; we1 = 1'b1;
    #1;
    checks++; if (gnt0 !== 1'b0) begin errors++; $display("FAIL rst_gnt0 got=%b exp=0", gnt0); end
    checks++; if (gnt1 !== 1'b0) begin errors++; $display("FAIL rst_gnt1 got=%b exp=0", gnt1); end
    checks++; if (mem_we !== 1'b0) begin errors++; $display("FAIL rst_mem_we got=%b exp=0", mem_we); end
    repeat (2) @(posedge clock);
    @(negedge clock);
    idle_inputs();
    reset = 1'b0;
    #1;
    checks++; if (rvalid0 !== 1'b0) begin errors++; $display("FAIL rst_rvalid0 got=%b exp=0", rvalid0); end
    checks++; if (rvalid1 !== 1'b0) begin errors++; $display("FAIL rst_rvalid1 got=%b exp=0", rvalid1); end
    checks++; if (rdata0 !== 32'd0) begin errors++; $display("FAIL rst_rdata0 got=%h exp=0", rdata0); end
    checks++; if (rdata1 !== 32'd0) begin errors++; $display("FAIL rst_rdata1 got=%h exp=0", rdata1); end
    checks++; if (mem_addr !== 32'd0) begin errors++; $display("FAIL idle_mem_addr got=%h exp=0", mem_addr); end
  endtask

  task automatic test_single_read();
    @(negedge clock);
    req0 = 1'b1; we0 = 1'b0; addr0 = 32'h10;
    #1;
    checks++; if (gnt0 !== 1'b1) begin errors++; $display("FAIL rd_gnt0 got=%b exp=1", gnt0); end
    checks++; if (gnt1 !== 1'b0) begin errors++; $display("FAIL rd_gnt1 got=%b exp=0", gnt1); end
    checks++; if (mem_addr !== 32'h10) begin errors++; $display("FAIL rd_mem_addr got=%h exp=10", mem_addr); end
    checks++; if (mem_we !== 1'b0) begin errors++; $display("FAIL rd_mem_we got=%b exp=0", mem_we); end
    @(negedge clock);
    req0 = 1'b0;
    #1;
    checks++; if (rvalid0 !== 1'b1) begin errors++; $display("FAIL rd_rvalid0 got=%b exp=1", rvalid0); end
    checks++; if (rdata0 !== 32'hDEADBEEF) begin errors++; $display("FAIL rd_rdata0 got=%h exp=deadbeef", rdata0); end
    checks++; if (rvalid1 !== 1'b0) begin errors++; $display("FAIL rd_rvalid1 got=%b exp=0", rvalid1); end
    @(negedge clock);
    #1;
    checks++; if (rvalid0 !== 1'b0) begin errors++; $display("FAIL rd_rvalid0_pulse got=%b exp=0", rvalid0); end
    checks++; if (rdata0 !== 32'hDEADBEEF) begin errors++; $display("FAIL rd_rdata0_hold got=%h exp=deadbeef", rdata0); end
  endtask

  task automatic test_round_robin();
    logic e0, rv0, rv1;
    do_reset();
    req0 = 1'b1; req1 = 1'b1; addr0 = 32'h30; addr1 = 32'h40;
    for (int i = 0; i < 4; i++) begin
      #1;
      e0  = (i % 2 == 0);
      rv0 = (i > 0) && ((i - 1) % 2 == 0);
      rv1 = (i > 0) && ((i - 1) % 2 == 1);
      checks++; if (gnt0 !== e0) begin errors++; $display("FAIL rr_gnt0[%0d] got=%b exp=%b", i, gnt0, e0); end
      checks++; if (gnt1 !== ~e0) begin errors++; $display("FAIL rr_gnt1[%0d] got=%b exp=%b", i, gnt1, ~e0); end
      checks++; if (rvalid0 !== rv0) begin errors++; $display("FAIL rr_rvalid0[%0d] got=%b exp=%b", i, rvalid0, rv0); end
      checks++; if (rvalid1 !== rv1) begin errors++; $display("FAIL rr_rvalid1[%0d] got=%b exp=%b", i, rvalid1, rv1); end
      if (rv0) begin
        checks++; if (rdata0 !== 32'hAAAA0000) begin errors++; $display("FAIL rr_rdata0[%0d] got=%h exp=aaaa0000", i, rdata0); end
      end
      if (rv1) begin
        checks++; if (rdata1 !== 32'hBBBB1111) begin errors++; $display("FAIL rr_rdata1[%0d] got=%h exp=bbbb1111", i, rdata1); end
      end
      @(negedge clock);
    end
    idle_inputs();
    #1;
    checks++; if (rvalid1 !== 1'b1) begin errors++; $display("FAIL rr_rvalid1_last got=%b exp=1", rvalid1); end
    checks++; if (rdata1 !== 32'hBBBB1111) begin errors++; $display("FAIL rr_rdata1_last got=%h exp=bbbb1111", rdata1); end
  endtask

  task automatic test_lock();
    logic [9:0] pat;
    logic e1, e0;
    int streak, worst;
    pat = 10'b0111101111;
    streak = 0; worst = 0;
    do_reset();
    for (int c = 0; c < 10; c++) begin
      req1 = 1'b1; lock1 = 1'b1; req0 = (c > 0);
      #1;
      e1 = pat[c];
      e0 = (c > 0) && !e1;
      checks++; if (gnt1 !== e1) begin errors++; $display("FAIL lock_gnt1[%0d] got=%b exp=%b", c, gnt1, e1); end
      checks++; if (gnt0 !== e0) begin errors++; $display("FAIL lock_gnt0[%0d] got=%b exp=%b", c, gnt0, e0); end
      if (req0 && !gnt0) streak++; else streak = 0;
      if (streak > worst) worst = streak;
      @(negedge clock);
    end
    idle_inputs();
    checks++; if (worst > 4) begin errors++; $display("FAIL lock_starve got=%0d exp<=4", worst); end
    @(negedge clock);
  endtask

  task automatic test_write_then_read();
    @(negedge clock);
    req0 = 1'b1; we0 = 1'b1; addr0 = 32'h20; wdata0 = 32'h12345678;
    #1;
    checks++; if (gnt0 !== 1'b1) begin errors++; $display("FAIL wr_gnt0 got=%b exp=1", gnt0); end
    checks++; if (mem_we !== 1'b1) begin errors++; $display("FAIL wr_mem_we got=%b exp=1", mem_we); end
    checks++; if (mem_wdata !== 32'h12345678) begin errors++; $display("FAIL wr_mem_wdata got=%h exp=12345678", mem_wdata); end
    @(negedge clock);
    req0 = 1'b0; we0 = 1'b0; req1 = 1'b1; we1 = 1'b0; addr1 = 32'h20;
    #1;
    checks++; if (gnt1 !== 1'b1) begin errors++; $display("FAIL wr_gnt1 got=%b exp=1", gnt1); end
    checks++; if (mem_we !== 1'b0) begin errors++; $display("FAIL wr_mem_we2 got=%b exp=0", mem_we); end
    checks++; if (rvalid0 !== 1'b0) begin errors++; $display("FAIL wr_no_rvalid got=%b exp=0", rvalid0); end
    @(negedge clock);
    idle_inputs();
    #1;
    checks++; if (rvalid1 !== 1'b1) begin errors++; $display("FAIL wr_rvalid1 got=%b exp=1", rvalid1); end
    checks++; if (rdata1 !== 32'h12345678) begin errors++; $display("FAIL wr_rdata1 got=%h exp=12345678", rdata1); end
  endtask

  task automatic test_reset_mid_read();
    @(negedge clock);
    req0 = 1'b1; we0 = 1'b0; addr0 = 32'h10;
    #1;
    checks++; if (gnt0 !== 1'b1) begin errors++; $display("FAIL mid_gnt0 got=%b exp=1", gnt0); end
    @(negedge clock);
    req0 = 1'b0; reset = 1'b1;
    #1;
    checks++; if (rvalid0 !== 1'b0) begin errors++; $display("FAIL mid_rvalid0_rst got=%b exp=0", rvalid0); end
    @(negedge clock);
    reset = 1'b0;
    #1;
    checks++; if (rvalid0 !== 1'b0) begin errors++; $display("FAIL mid_rvalid0_after got=%b exp=0", rvalid0); end
    checks++; if (rdata0 !== 32'd0) begin errors++; $display("FAIL mid_rdata0 got=%h exp=0", rdata0); end
    req0 = 1'b1; req1 = 1'b1;
    #1;
    checks++; if (gnt0 !== 1'b1 || gnt1 !== 1'b0) begin errors++; $display("FAIL mid_idle_tie got=%b%b exp=10", gnt0, gnt1); end
    @(negedge clock);
    idle_inputs();
  endtask

`ifdef ARB_STATS_EN
  task automatic test_stats();
    do_reset();
    req0 = 1'b1; req1 = 1'b1;
    repeat (10) @(negedge clock);
    idle_inputs();
    #1;
    checks++; if (conflicts !== 32'd10) begin errors++; $display("FAIL st_conflicts got=%0d exp=10", conflicts); end
    checks++; if (stall0 !== 32'd5) begin errors++; $display("FAIL st_stall0 got=%0d exp=5", stall0); end
    checks++; if (stall1 !== 32'd5) begin errors++; $display("FAIL st_stall1 got=%0d exp=5", stall1); end
  endtask
`endif

  initial begin
    #200000;
    $display("FAIL timeout");
    $fatal(1, "timeout");
  end

  initial begin
    for (int i = 0; i < 256; i++) ram[i] = 32'd0;
    ram[8'h10] = 32'hDEADBEEF;
    ram[8'h30] = 32'hAAAA0000;
    ram[8'h40] = 32'hBBBB1111;
    test_reset();
    test_single_read();
    test_round_robin();
    test_lock();
    test_write_then_read();
    test_reset_mid_read();
`ifdef ARB_STATS_EN
    test_stats();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/ram_arbiter.md
Name: ram_arbiter

Overview:
- Shares the single-port data RAM behind the panel between two requesters: port 0 is the core data port, port 1 is a secondary master (display scanner or loader).
- Round-robin arbitration, with optional locked bursts and a bounded lock length so neither port starves.
- Sits between the requesters and the panel's address/wdata/enw/rdata port, in the core clock domain.

Parameters:
- WIDTH, 32, data and address width in bits
- MAX_LOCK, 16, maximum consecutive cycles one port may hold a lock before forced release
- RD_LAT, 1, RAM read latency in cycles; legal values 1 or 2

Ports:
- clock  in  1  core clock
- reset  in  1  synchronous, active-high reset
- req0, req1  in  1  access request, one per port
- lock0, lock1  in  1  request to keep ownership on following cycles
- we0, we1  in  1  write enable (1 = write, 0 = read)
- addr0, addr1  in  WIDTH  word address
- wdata0, wdata1  in  WIDTH  write data
- gnt0, gnt1  out  1  access accepted this cycle (combinational)
- rvalid0, rvalid1  out  1  read data valid, RD_LAT cycles after a granted read
- rdata0, rdata1  out  WIDTH  read data, held until the next rvalid for that port
- mem_addr  out  WIDTH  RAM address
- mem_wdata  out  WIDTH  RAM write data
- mem_we  out  1  RAM write strobe
- mem_rdata  in  WIDTH  RAM read data

Behaviour:
- State machine OWNER: IDLE, OWN0, OWN1. Register last (last-served port) and lock_cnt (width $clog2(MAX_LOCK)+1).
- Reset (synchronous, takes effect at clock edge while reset=1):
  - state=IDLE, last=1 so port 0 wins the first tie, lock_cnt=0.
  - rvalid0/1=0, rdata0/1=0, read-return pipeline cleared.
  - While reset=1: gnt0/1=0 and mem_we=0 regardless of req.
- Grant rule, evaluated every cycle:
  - IDLE or unlocked owner: a lone requester is granted. If both request, grant the port != last.
  - OWNk with lockk=1 and lock_cnt<MAX_LOCK: port k is granted if reqk=1; the other port is held off.
  - OWNk with lock_cnt==MAX_LOCK: port k is denied for exactly one cycle if the other port requests. If the other port does not request, k continues and lock_cnt saturates.
- At most one gnt high per cycle; gnt0&gnt1 never 1.
- Memory side: mem_addr/mem_wdata mux from the granted port. mem_we = gnt & we of the granted port. With no grant: mem_addr=0, mem_wdata=0, mem_we=0.
- Transitions:
  - On grant to k: state=OWNk, last=k.
  - lock_cnt increments while the owner is granted with lock=1. It resets to 0 on a change of owner or when lock=0.
  - Owner deasserts both req and lock: state=IDLE.
- Reads: a granted read tags the port into an RD_LAT-deep pipeline. RD_LAT cycles later, rvalidk=1 for one cycle and rdatak=mem_rdata.
- Back-to-back reads from alternating ports return in issue order, one per cycle, no bubble.
- Writes produce no rvalid.
- Reset mid-operation: in-flight reads are discarded; no rvalid is emitted after reset.
- req dropped without a grant: no side effects. Requesters hold addr/we/wdata stable until granted.

Optional Feature:
- Macro ARB_STATS_EN.
- Defined: adds outputs conflicts (32 bits, counts cycles where req0&req1), stall0 and stall1 (32 bits each, count cycles reqk&~gntk). All reset to 0 and saturate at all-ones.
- Undefined: ports and counters are absent; all other behaviour is identical.

Test Plan:
- Reset, then req0=1 we0=0 addr0=0x10 with RAM[0x10]=0xDEADBEEF -> gnt0=1 same cycle; rvalid0=1 and rdata0=0xDEADBEEF one cycle later (RD_LAT=1).
- req0=req1=1, no locks, for 4 cycles from reset -> grants alternate 0,1,0,1; rvalid0/rvalid1 alternate with the correct data.
- lock1=1 and req1 held, req0=1 continuously, MAX_LOCK=4 -> gnt1 for 4 cycles, then gnt0 for 1 cycle, then gnt1 resumes; gnt0 is never starved more than 4 cycles.
- Port 0 write addr 0x20 data 0x12345678, then port 1 read addr 0x20 on the next cycle -> mem_we=1 only on the first cycle; rdata1=0x12345678.
- Granted read issued, reset asserted on the following cycle -> rvalid0 stays 0, rdata0=0, state returns to IDLE.
- With ARB_STATS_EN: 10 cycles of req0=req1=1 without locks -> conflicts=10, stall0=5, stall1=5.
